// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch path: queue entry layout and sequencer states.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small register-based FIFO of fetched {pc, instr} entries.
// The head entry is read straight out of registers, so a push into an empty queue is visible after the same edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;

  assign pop_eff = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Flush wins over a same-cycle push; the slot contents are left as-is.
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/imem_fetch_controller.sv
// IF-stage sequencer: owns the PC, reads the combinational instruction memory and feeds decode
// through a prefetch queue; redirects flush the queue, illegal PCs park the sequencer in FAULT.
module imem_fetch_controller
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES   = 512,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int          CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - INSTR_BYTES);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic             pc_legal;
  logic             pop;
  logic             push;
  logic             flush;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] unused_count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign pc_legal   = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_WORD);
  assign pop        = out_valid && out_ready;
  assign push_entry = '{pc: pc_q, instr: imem_instruction};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = FETCH;
    end else if (state_q == FETCH) begin
      if (!pc_legal) begin
        state_d    = FAULT;
        fault_pc_d = pc_q;
      end else if (!q_full || pop) begin
        push = 1'b1;
        pc_d = pc_q + 32'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (unused_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign imem_address    = pc_q;
  assign out_valid       = !q_empty;
  assign out_instruction = head_entry.instr;
  assign out_pc          = head_entry.pc;
  assign fault           = (state_q == FAULT);
  assign fault_pc        = fault_pc_q;

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller with a behavioural 512 B instruction memory.
module tb_imem_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int total = 0;
  int bad   = 0;

  imem_fetch_controller dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .fault            (fault),
    .fault_pc         (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)         return 32'h0000_0013;
    else if (a == 32'h4)    return 32'h0010_0093;
    else if (a <= 32'h1FC)  return 32'hC0DE_0000 | a;
    else                    return 32'hDEAD_BEEF;
  endfunction

  assign imem_instruction = mem_word(imem_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instruction, mem_word(pc));
    $display("step %s: out_valid=%0b out_pc=%h out_instr=%h addr=%h fault=%0b",
             tag, out_valid, out_pc, out_instruction, imem_address, fault);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instruction, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_addr", imem_address, 32'd0);

    // Streaming with decode always ready.
    @(negedge clk); reset = 1'b0;
    tick(); head("seq0", 32'h0); chk("seq0_addr", imem_address, 32'h4);
    tick(); head("seq1", 32'h4); chk("seq1_addr", imem_address, 32'h8);
    tick(); head("seq2", 32'h8); chk("seq2_addr", imem_address, 32'hC);

    // Backpressure from reset: queue fills, pc parks at 8.
    reset = 1'b1; #1; reset = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) tick();
    head("bp_hold", 32'h0);
    chk("bp_addr", imem_address, 32'h8);
    out_ready = 1'b1;
    tick(); head("bp_rel1", 32'h4);
    tick(); head("bp_rel2", 32'h8);

    // Redirect while queue holds 8 and 12.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("rd_flush_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", imem_address, 32'h40);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick(); head("rd_first", 32'h40);
    tick(); head("rd_second", 32'h44);

    // Run off the end of memory with decode stalled, then drain.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1F8;
    tick(); redirect_valid = 1'b0;
    tick(); tick(); tick();
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_fault_pc", fault_pc, 32'h200);
    chk("end_addr", imem_address, 32'h200);
    head("end_h0", 32'h1F8);
    out_ready = 1'b1;
    tick(); head("end_h1", 32'h1FC);
    tick(); chk("end_drained", 32'(out_valid), 32'd0);
    tick(); chk("end_stays_empty", 32'(out_valid), 32'd0);
    chk("end_fault_held", 32'(fault), 32'd1);
    chk("end_addr_frozen", imem_address, 32'h200);

    // Misaligned redirect, then recover.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick(); redirect_valid = 1'b0;
    chk("mis_fault_clr", 32'(fault), 32'd0);
    tick();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h6);
    chk("mis_valid", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick(); redirect_valid = 1'b0;
    chk("rec_fault", 32'(fault), 32'd0);
    chk("rec_valid", 32'(out_valid), 32'd0);
    tick(); head("rec_first", 32'h10);

    // Asynchronous reset with a full queue and a redirect in flight.
    out_ready = 1'b0;
    tick();
    chk("ar_full_head", out_pc, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    #2; reset = 1'b1; #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_instr", out_instruction, 32'd0);
    chk("ar_pc", out_pc, 32'd0);
    chk("ar_fault", 32'(fault), 32'd0);
    chk("ar_fault_pc", fault_pc, 32'd0);
    chk("ar_addr", imem_address, 32'd0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); reset = 1'b0;
    tick(); head("ar_restart", 32'h0);
    chk("ar_restart_addr", imem_address, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
